// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer RAM sequencer: display prefetch FIFO with urgency priority, two round-robin paint writers.
// Define ARB_PERF_CNT_EN to add the wr_stall_cnt writer-stall counter output.

module fb_access_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int NPIX       = 307200,
  parameter int FIFO_DEPTH = 8,
  parameter int URGENT_LVL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_pop,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_underrun,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr0_gnt,
  output logic              wr1_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       wr_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = CNT_W + 1;
  localparam logic [LVL_W-1:0]  URGENT_L  = LVL_W'(URGENT_LVL);
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e            state_q;
  logic              flush_cnt_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              rr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              rd_ret_q;
  logic              underrun_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              gnt0_q;
  logic              gnt1_q;

  logic              run_ok;
  logic              elig0;
  logic              elig1;
  logic              do_read;
  logic              grant0;
  logic              grant1;
  logic              rr_d;
  logic              push;
  logic              pop_ok;
  logic              pop_empty;
  logic [LVL_W-1:0]  level;

  // Reads still in the RAM pipe count toward the level so the FIFO can never overflow.
  assign run_ok    = (state_q == ST_RUN) && !frame_start;
  assign level     = LVL_W'(count_q) + LVL_W'(mem_en_q & ~mem_we_q) + LVL_W'(rd_ret_q);
  assign elig0     = wr0_req && !gnt0_q;
  assign elig1     = wr1_req && !gnt1_q;
  assign push      = rd_ret_q && run_ok;
  assign pop_ok    = disp_pop && (count_q != '0) && !frame_start;
  assign pop_empty = disp_pop && (count_q == '0) && !frame_start;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    do_read = 1'b0;
    grant0  = 1'b0;
    grant1  = 1'b0;
    rr_d    = rr_q;
    if (run_ok && level <= URGENT_L) begin
      do_read = 1'b1;
    end else if (elig0 && elig1) begin
      grant0 = !rr_q;
      grant1 = rr_q;
      rr_d   = !rr_q;
    end else if (elig0) begin
      grant0 = 1'b1;
    end else if (elig1) begin
      grant1 = 1'b1;
    end else if (run_ok && level < DEPTH_L) begin
      do_read = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= 1'b0;
      fetch_addr_q <= '0;
      rr_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_ret_q     <= 1'b0;
      underrun_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      rd_ret_q    <= mem_en_q & ~mem_we_q;
      rr_q        <= rr_d;
      gnt0_q      <= grant0;
      gnt1_q      <= grant1;
      mem_en_q    <= do_read | grant0 | grant1;
      mem_we_q    <= grant0 | grant1;
      mem_addr_q  <= grant0 ? wr0_addr : grant1 ? wr1_addr : do_read ? fetch_addr_q : '0;
      mem_wdata_q <= grant0 ? wr0_data : grant1 ? wr1_data : '0;

      if (frame_start) begin
        state_q      <= ST_FLUSH;
        flush_cnt_q  <= 1'b0;
        fetch_addr_q <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
        underrun_q   <= 1'b0;
      end else begin
        if (state_q == ST_FLUSH) begin
          if (flush_cnt_q) state_q <= ST_RUN;
          flush_cnt_q <= 1'b1;
        end
        if (do_read) fetch_addr_q <= (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + 1'b1;
        if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop_ok)      count_q <= count_q + 1'b1;
        else if (!push && pop_ok) count_q <= count_q - 1'b1;
        if (pop_empty) underrun_q <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; disp_data is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

  assign disp_valid    = (count_q != '0);
  assign disp_data     = disp_valid ? fifo_mem[rd_ptr_q] : '0;
  assign disp_underrun = underrun_q;
  assign wr0_gnt       = gnt0_q;
  assign wr1_gnt       = gnt1_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (frame_start) begin
      stall_cnt_q <= '0;
    end else if ((wr0_req || wr1_req) && !(grant0 || grant1) && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomized bench for fb_access_arbiter against a queue-based reference model of the arbitration rules.
// Uses a small NPIX so the fetch-address wrap is reached in a short run.

module tb_fb_access_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int NPIX       = 1000;
  localparam int FIFO_DEPTH = 8;
  localparam int URGENT_LVL = 3;

  logic              clk;
  logic              rst_n;
  logic              frame_start;
  logic              disp_pop;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_underrun;
  logic              wr0_req;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_req;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr0_gnt;
  logic              wr1_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]       wr_stall_cnt;
`endif

  fb_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX),
    .FIFO_DEPTH(FIFO_DEPTH), .URGENT_LVL(URGENT_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .disp_pop(disp_pop),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_underrun(disp_underrun),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // RAM content is a fixed function of the address; non-read cycles return junk.
  function automatic logic [7:0] pix(input int a);
    return 8'((a * 13) ^ (a >> 7) ^ 32'h5A);
  endfunction

  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? pix(int'(mem_addr)) : 8'($urandom());

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of pixels, reads in flight as a queue of (addr, issue cycle).
  typedef struct {int addr; int cyc;} rd_t;
  logic [7:0] m_fifo[$];
  rd_t        m_rd[$];
  int         cyc;
  int         m_addr, m_flush, m_rr, m_last, m_stall;
  bit         m_unr;
  bit         e_en, e_we, e_g0, e_g1;
  int         e_addr;
  logic [7:0] e_wdata;

  task automatic model_reset();
    m_fifo.delete();
    m_rd.delete();
    m_addr  = 0;
    m_flush = 0;
    m_rr    = 0;
    m_last  = -1;
    m_stall = 0;
    m_unr   = 0;
    e_en = 0; e_we = 0; e_g0 = 0; e_g1 = 0;
    e_addr  = 0;
    e_wdata = 8'h00;
  endtask

  task automatic model_step();
    int level;
    bit run, ret, el0, el1, g0, g1, rd;
    logic [7:0] ret_pix;
    level = m_fifo.size() + m_rd.size();
    ret = 0;
    ret_pix = 8'h00;
    if (m_rd.size() > 0 && m_rd[0].cyc + 2 == cyc) begin
      ret = 1;
      ret_pix = pix(m_rd[0].addr);
      void'(m_rd.pop_front());
    end
    run = (m_flush == 0) && !frame_start;
    el0 = wr0_req && (m_last != 0);
    el1 = wr1_req && (m_last != 1);
    g0 = 0; g1 = 0; rd = 0;
    if (run && level <= URGENT_LVL) rd = 1;
    else if (el0 && el1) begin
      if (m_rr == 0) g0 = 1; else g1 = 1;
      m_rr = 1 - m_rr;
    end
    else if (el0) g0 = 1;
    else if (el1) g1 = 1;
    else if (run && level < FIFO_DEPTH) rd = 1;
    e_en = rd | g0 | g1;
    e_we = g0 | g1;
    e_g0 = g0;
    e_g1 = g1;
    e_addr  = g0 ? int'(wr0_addr) : g1 ? int'(wr1_addr) : m_addr;
    e_wdata = g0 ? wr0_data : wr1_data;
    if (frame_start) m_stall = 0;
    else if ((wr0_req || wr1_req) && !g0 && !g1 && m_stall < 65535) m_stall++;
    if (rd) begin
      m_rd.push_back('{m_addr, cyc});
      m_addr = (m_addr == NPIX - 1) ? 0 : m_addr + 1;
    end
    if (frame_start) begin
      m_fifo.delete();
      m_rd.delete();
      m_addr  = 0;
      m_unr   = 0;
      m_flush = 2;
    end else begin
      if (disp_pop) begin
        if (m_fifo.size() == 0) m_unr = 1;
        else void'(m_fifo.pop_front());
      end
      if (ret && m_flush == 0) m_fifo.push_back(ret_pix);
      if (m_flush > 0) m_flush--;
    end
    m_last = g0 ? 0 : g1 ? 1 : -1;
    cyc++;
  endtask

  task automatic compare_outputs();
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_we);
    if (e_en) check("mem_addr", mem_addr, e_addr);
    if (e_en && e_we) check("mem_wdata", mem_wdata, e_wdata);
    check("wr0_gnt", wr0_gnt, e_g0);
    check("wr1_gnt", wr1_gnt, e_g1);
    check("disp_valid", disp_valid, m_fifo.size() > 0);
    check("disp_data", disp_data, (m_fifo.size() > 0) ? m_fifo[0] : 8'h00);
    check("disp_underrun", disp_underrun, m_unr);
`ifdef ARB_PERF_CNT_EN
    check("wr_stall_cnt", wr_stall_cnt, m_stall);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  // Writers hold req until granted, then optionally issue a fresh request at once.
  task automatic drive(input int p_pop, input int p_w0, input int p_w1);
    disp_pop    = int'($urandom_range(99)) < p_pop;
    frame_start = 1'b0;
    if (wr0_gnt || !wr0_req) begin
      wr0_req  = int'($urandom_range(99)) < p_w0;
      wr0_addr = ADDR_W'($urandom());
      wr0_data = 8'($urandom());
    end
    if (wr1_gnt || !wr1_req) begin
      wr1_req  = int'($urandom_range(99)) < p_w1;
      wr1_addr = ADDR_W'($urandom());
      wr1_data = 8'($urandom());
    end
  endtask

  initial begin
    int  idx;
    int  lw;
    bit  pg0, pg1, found;
    int  pp, pw0, pw1;
    cyc = 0;
    rst_n = 1'b0; frame_start = 1'b0; disp_pop = 1'b0;
    wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    model_reset();
    tick();
    tick();

    // Fill after reset release with idle writers.
    rst_n = 1'b1;
    tick();
    check("first_mem_en", mem_en, 1);
    check("first_mem_addr", mem_addr, 0);
    tick();
    check("fill_valid_early", disp_valid, 0);
    tick();
    check("fill_valid", disp_valid, 1);
    check("fill_first_pix", disp_data, pix(0));
    repeat (10) begin drive(0, 0, 0); tick(); end
    check("fill_idle", mem_en, 0);

    // Full frame of pops with no writers, crossing the address wrap.
    frame_start = 1'b1;
    tick();
    repeat (14) begin drive(0, 0, 0); tick(); end
    idx = 0;
    repeat (NPIX + 50) begin
      drive(0, 0, 0);
      disp_pop = 1'b1;
      check("frame_pix", disp_data, pix(idx % NPIX));
      idx++;
      tick();
    end
    check("frame_no_underrun", disp_underrun, 0);

    // Both writers hammer with the FIFO full.
    repeat (6) begin drive(0, 0, 0); tick(); end
    lw = -1; pg0 = 0; pg1 = 0;
    repeat (40) begin
      drive(0, 100, 100);
      tick();
      check("b2b_gnt", (wr0_gnt && pg0) || (wr1_gnt && pg1), 0);
      if (wr0_gnt || wr1_gnt) begin
        check("one_gnt", wr0_gnt && wr1_gnt, 0);
        if (lw >= 0) check("rr_alternate", wr1_gnt, lw == 0);
        lw = wr1_gnt ? 1 : 0;
      end
      pg0 = wr0_gnt;
      pg1 = wr1_gnt;
    end

    // Pop every cycle while both writers hammer.
    repeat (200) begin drive(100, 100, 100); tick(); end
    check("hammer_no_underrun", disp_underrun, 0);

    // frame_start with reads in flight, then a write during FLUSH.
    repeat (6) begin drive(0, 0, 0); tick(); end
    repeat (12) begin drive(100, 0, 0); tick(); end
    check("pre_fs_read", mem_en && !mem_we, 1);
    frame_start = 1'b1; disp_pop = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    tick();
    frame_start = 1'b0;
    check("fs_empty", disp_valid, 0);
    wr0_req = 1'b1; wr0_addr = 19'h5A5A5; wr0_data = 8'hC3;
    tick();
    check("flush_wr_gnt", wr0_gnt, 1);
    check("flush_wr_addr", mem_addr, 19'h5A5A5);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(0, 0, 0);
      tick();
      if (mem_en && !mem_we) begin
        found = 1;
        check("flush_first_addr", mem_addr, 0);
      end
    end
    check("flush_read_seen", found, 1);

    // Asynchronous reset mid-access, then a pop on the empty FIFO.
    repeat (4) begin drive(0, 0, 0); tick(); end
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_mem_en", mem_en, 0);
    check("rst_async_valid", disp_valid, 0);
    tick();
    tick();
    rst_n = 1'b1; disp_pop = 1'b1; wr0_req = 1'b0;
    wr1_req = 1'b1; wr1_addr = 19'h00123; wr1_data = 8'h77;
    tick();
    check("underrun_set", disp_underrun, 1);
`ifdef ARB_PERF_CNT_EN
    check("stall_first", wr_stall_cnt, 1);
`endif
    repeat (5) begin drive(0, 0, 50); tick(); end
    check("underrun_held", disp_underrun, 1);
    drive(0, 0, 0);
    frame_start = 1'b1;
    tick();
    check("underrun_clr", disp_underrun, 0);

    // Randomized traffic with occasional frame starts.
    for (int s = 0; s < 6; s++) begin
      pp  = int'($urandom_range(100));
      pw0 = int'($urandom_range(100));
      pw1 = int'($urandom_range(100));
      repeat (500) begin
        drive(pp, pw0, pw1);
        if ($urandom_range(199) == 0) frame_start = 1'b1;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
